broadcast_ctrl: RTL and testbench
=================================

BROADCAST_CTRL -- requirements
Module: broadcast_ctrl

Interface
REQ-001 Parameter: MAX_VECTOR_SIZE, default 8, lanes per broadcast vector and bytes per SRAM word.
REQ-002 Parameter: CACHE_DEPTH, default 512, broadcast cache entries.
REQ-003 Parameter: RD_MAX_OUTSTANDING, default 4, maximum SRAM reads in flight.
REQ-004 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Ports: start_i in 1, job launch pulse; src_addr_i in MAX_ADDR_WIDTH, SRAM word address of the broadcast operand.
REQ-007 Ports: num_elem_i in INT32_SIZE, operand length in elements; num_vec_i in INT32_SIZE, output vectors to broadcast.
REQ-008 Ports: sram_rd_en_o out 1 and sram_rd_addr_o out MAX_ADDR_WIDTH, read request; sram_rd_valid_i in 1 and sram_rd_data_i in INT8_SIZE*8, read return in issue order.
REQ-009 Ports to broadcast unit: bu_init_o 1; bu_valid_o 1; bu_addr_o MAX_ADDR_WIDTH; bu_data_o INT8_SIZE*8; bu_en_o 1; bu_num_elem_o INT32_SIZE.
REQ-010 Ports: out_ready_i in 1, downstream consumer ready; busy_o out 1; done_o out 1, one-cycle pulse; err_o out 1, sticky until next accepted start.

Function
REQ-011 FSM states: IDLE, INIT, LOAD, DRAIN, STREAM, DONE.
REQ-012 IDLE: start_i accepted only in IDLE; job inputs latched on acceptance; start_i in any other state ignored.
REQ-013 On acceptance with num_elem_i==0, num_elem_i>CACHE_DEPTH or num_vec_i==0: set err_o, go DONE, no SRAM reads, no bu_en_o.
REQ-014 Valid acceptance -> INIT: bu_init_o high exactly one cycle, clear err_o, then LOAD.
REQ-015 LOAD: issue W=ceil(num_elem/MAX_VECTOR_SIZE) reads at src_addr+0..W-1, one per cycle, while outstanding count < RD_MAX_OUTSTANDING.
REQ-016 Outstanding counter: +1 on issue, -1 on sram_rd_valid_i; simultaneous issue and return leaves it unchanged.
REQ-017 Each return k: bu_valid_o=1, bu_data_o=sram_rd_data_i, bu_addr_o=k*MAX_VECTOR_SIZE, same cycle (combinational pass-through, zero latency).
REQ-018 After W issued -> DRAIN; after W-th return -> STREAM next cycle.
REQ-019 STREAM: bu_en_o = out_ready_i; vector counter increments per cycle with bu_en_o high; after num_vec enabled cycles -> DONE.
REQ-020 out_ready_i low: bu_en_o low, counter held, state held; no limit on stall length.
REQ-021 bu_num_elem_o = latched num_elem, held constant from INIT through DONE.
REQ-022 DONE: done_o high one cycle, back to IDLE; busy_o high in every state except IDLE.
REQ-023 sram_rd_valid_i outside LOAD/DRAIN ignored, never forwarded to bu_valid_o.

Reset
REQ-024 rst asserted: state IDLE, counters 0, all outputs 0, regardless of state, including mid-LOAD or mid-STREAM.
REQ-025 In-flight SRAM returns after rst release fall under REQ-023.

Configuration
REQ-026 Macro BROADCAST_CTRL_PERF_EN defined: add outputs perf_stall_cnt_o and perf_load_cnt_o, 32 bits each; they count STREAM cycles with out_ready_i low and cycles in LOAD+DRAIN, are cleared on accepted start, and saturate.
REQ-027 Macro undefined: those ports and counters do not exist; all other behaviour is identical.

Structure
REQ-028 FSM state encoding and the CACHE_DEPTH default go in params.vh alongside INT8_SIZE, INT32_SIZE and MAX_ADDR_WIDTH.
REQ-029 Sub-module rd_credit_ctr holds the outstanding-read counter; the rest stays flat.

Verification
REQ-030 num_elem=20, num_vec=3, src=0x40, 1-cycle SRAM, ready=1 -> reads at 0x40..0x42; bu_addr 0,8,16; 3 bu_en cycles; one done pulse.
REQ-031 num_elem=64, SRAM latency 6 -> outstanding never >4; exactly 8 reads; returns map to bu_addr 0..56 in order.
REQ-032 num_vec=5, ready pattern 1,0,0,1,1,0,1,1 -> exactly 5 bu_en cycles; with PERF_EN, stall count=3.
REQ-033 num_elem=0, then num_elem=600 -> err_o set, done pulse, no reads; next valid start clears err_o.
REQ-034 rst pulse mid-LOAD with 2 reads outstanding -> outputs 0 next cycle; late returns do not raise bu_valid_o; new job runs cleanly.
REQ-035 start_i re-pulsed during STREAM -> ignored, job completes unchanged.

Source files
------------

// File: rtl/broadcast_ctrl_pkg.sv
// broadcast_ctrl_pkg
// Shared widths, the controller state encoding, the default broadcast cache
// depth and a ceiling-divide helper used to size the SRAM load.
package broadcast_ctrl_pkg;

  localparam int INT8_SIZE       = 8;
  localparam int INT32_SIZE      = 32;
  localparam int MAX_ADDR_WIDTH  = 16;
  localparam int CACHE_DEPTH_DEF = 512;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_STREAM = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic logic [INT32_SIZE-1:0] ceil_div(input logic [INT32_SIZE-1:0] n,
                                                     input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/broadcast_ctrl_rd_credit.sv
// rd_credit_ctr
// Counts SRAM reads in flight and reports whether another read may issue.
// Ports:
//   clk, rst  - clock, async active-high reset
//   clr       - synchronous clear at job launch
//   inc       - a read was issued this cycle
//   dec       - a read returned this cycle
//   cnt       - reads currently outstanding
//   avail     - cnt below MAX_OUT, a new read may issue
module rd_credit_ctr #(
  parameter int MAX_OUT = 4,
  parameter int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          avail
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   cnt <= cnt + CW'(1);
        // a stray return with nothing outstanding must not wrap the count
        2'b01:   if (cnt != '0) cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign avail = (cnt < CW'(MAX_OUT));

endmodule

// File: rtl/broadcast_ctrl.sv
// broadcast_ctrl
// Loads a broadcast operand from SRAM into the broadcast unit cache, then
// enables the broadcast unit for num_vec output vectors.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   start_i, src_addr_i,
//   num_elem_i, num_vec_i    - job launch and job parameters (latched in IDLE)
//   sram_rd_en_o/addr_o      - SRAM read request
//   sram_rd_valid_i/data_i   - SRAM read return, in issue order
//   bu_*                     - broadcast unit init / cache write / enable
//   out_ready_i              - downstream ready, gates bu_en_o while streaming
//   busy_o, done_o, err_o    - status; done_o pulses, err_o sticky
//   perf_stall_cnt_o,
//   perf_load_cnt_o          - only with BROADCAST_CTRL_PERF_EN defined
//
// state  | meaning
// IDLE   | waiting for start_i
// INIT   | one-cycle broadcast unit init
// LOAD   | issuing SRAM reads, credit limited
// DRAIN  | all reads issued, waiting for the last return
// STREAM | enabling broadcast unit while out_ready_i is high
// DONE   | one-cycle done pulse
module broadcast_ctrl
  import broadcast_ctrl_pkg::*;
#(
  parameter int MAX_VECTOR_SIZE    = 8,
  parameter int CACHE_DEPTH        = CACHE_DEPTH_DEF,
  parameter int RD_MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [MAX_ADDR_WIDTH-1:0] src_addr_i,
  input  logic [INT32_SIZE-1:0]     num_elem_i,
  input  logic [INT32_SIZE-1:0]     num_vec_i,
  output logic                      sram_rd_en_o,
  output logic [MAX_ADDR_WIDTH-1:0] sram_rd_addr_o,
  input  logic                      sram_rd_valid_i,
  input  logic [INT8_SIZE*8-1:0]    sram_rd_data_i,
  output logic                      bu_init_o,
  output logic                      bu_valid_o,
  output logic [MAX_ADDR_WIDTH-1:0] bu_addr_o,
  output logic [INT8_SIZE*8-1:0]    bu_data_o,
  output logic                      bu_en_o,
  output logic [INT32_SIZE-1:0]     bu_num_elem_o,
  input  logic                      out_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
`ifdef BROADCAST_CTRL_PERF_EN
  output logic [31:0]               perf_stall_cnt_o,
  output logic [31:0]               perf_load_cnt_o,
`endif
  output logic                      err_o
);

  localparam int AW = MAX_ADDR_WIDTH;
  localparam int CW = $clog2(RD_MAX_OUTSTANDING + 1);

  state_t                state_q, state_d;
  logic [AW-1:0]         src_q;
  logic [INT32_SIZE-1:0] num_elem_q, num_vec_q, words_q;
  logic [INT32_SIZE-1:0] iss_cnt_q, ret_cnt_q, vec_cnt_q;
  logic                  err_q;

  logic                  accept, job_bad, issue, ret, stream_en;
  logic                  last_issue, last_ret, last_vec;
  logic [CW-1:0]         out_cnt;
  logic                  credit_ok;

  assign accept    = (state_q == ST_IDLE) && start_i;
  assign job_bad   = (num_elem_i == '0) || (num_elem_i > INT32_SIZE'(CACHE_DEPTH)) ||
                     (num_vec_i == '0);
  assign issue     = (state_q == ST_LOAD) && credit_ok;
  // returns only count while a load is in progress; anything else is stale
  assign ret       = sram_rd_valid_i && ((state_q == ST_LOAD) || (state_q == ST_DRAIN));
  assign stream_en = (state_q == ST_STREAM) && out_ready_i;

  assign last_issue = issue && (iss_cnt_q == words_q - 32'd1);
  assign last_ret   = ret && (ret_cnt_q == words_q - 32'd1);
  assign last_vec   = stream_en && (vec_cnt_q == num_vec_q - 32'd1);

  rd_credit_ctr #(
    .MAX_OUT (RD_MAX_OUTSTANDING),
    .CW      (CW)
  ) u_rd_credit (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (issue),
    .dec   (ret),
    .cnt   (out_cnt),
    .avail (credit_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_i) state_d = job_bad ? ST_DONE : ST_INIT;
      ST_INIT:   state_d = ST_LOAD;
      ST_LOAD:   if (last_issue) state_d = ST_DRAIN;
      // the final return always lands after the final issue, so only DRAIN sees it
      ST_DRAIN:  if (last_ret) state_d = ST_STREAM;
      ST_STREAM: if (last_vec) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q      <= '0;
      num_elem_q <= '0;
      num_vec_q  <= '0;
      words_q    <= '0;
      iss_cnt_q  <= '0;
      ret_cnt_q  <= '0;
      vec_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      src_q      <= src_addr_i;
      num_elem_q <= num_elem_i;
      num_vec_q  <= num_vec_i;
      words_q    <= ceil_div(num_elem_i, MAX_VECTOR_SIZE);
      iss_cnt_q  <= '0;
      ret_cnt_q  <= '0;
      vec_cnt_q  <= '0;
      err_q      <= job_bad;
    end else begin
      if (issue)     iss_cnt_q <= iss_cnt_q + 32'd1;
      if (ret)       ret_cnt_q <= ret_cnt_q + 32'd1;
      if (stream_en) vec_cnt_q <= vec_cnt_q + 32'd1;
    end
  end

  assign sram_rd_en_o   = issue;
  assign sram_rd_addr_o = issue ? (src_q + iss_cnt_q[AW-1:0]) : '0;
  assign bu_init_o      = (state_q == ST_INIT);
  assign bu_valid_o     = ret;
  assign bu_data_o      = ret ? sram_rd_data_i : '0;
  assign bu_addr_o      = ret ? AW'(ret_cnt_q * MAX_VECTOR_SIZE) : '0;
  assign bu_en_o        = stream_en;
  assign bu_num_elem_o  = num_elem_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);
  assign err_o          = err_q;

`ifdef BROADCAST_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_load_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_load_q  <= '0;
    end else if (accept) begin
      perf_stall_q <= '0;
      perf_load_q  <= '0;
    end else begin
      if ((state_q == ST_STREAM) && !out_ready_i && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
      if (((state_q == ST_LOAD) || (state_q == ST_DRAIN)) && (perf_load_q != '1))
        perf_load_q <= perf_load_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_load_cnt_o  = perf_load_q;
`endif

endmodule

// File: tb/tb_broadcast_ctrl.sv
module tb_broadcast_ctrl;
  import broadcast_ctrl_pkg::*;

  localparam int AW = MAX_ADDR_WIDTH;
  localparam int DW = INT8_SIZE * 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start_i;
  logic [AW-1:0]         src_addr_i;
  logic [INT32_SIZE-1:0] num_elem_i, num_vec_i;
  logic                  sram_rd_en_o;
  logic [AW-1:0]         sram_rd_addr_o;
  logic                  sram_rd_valid_i;
  logic [DW-1:0]         sram_rd_data_i;
  logic                  bu_init_o, bu_valid_o, bu_en_o;
  logic [AW-1:0]         bu_addr_o;
  logic [DW-1:0]         bu_data_o;
  logic [INT32_SIZE-1:0] bu_num_elem_o;
  logic                  out_ready_i;
  logic                  busy_o, done_o, err_o;
`ifdef BROADCAST_CTRL_PERF_EN
  logic [31:0]           perf_stall_cnt_o, perf_load_cnt_o;
`endif

  broadcast_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .src_addr_i      (src_addr_i),
    .num_elem_i      (num_elem_i),
    .num_vec_i       (num_vec_i),
    .sram_rd_en_o    (sram_rd_en_o),
    .sram_rd_addr_o  (sram_rd_addr_o),
    .sram_rd_valid_i (sram_rd_valid_i),
    .sram_rd_data_i  (sram_rd_data_i),
    .bu_init_o       (bu_init_o),
    .bu_valid_o      (bu_valid_o),
    .bu_addr_o       (bu_addr_o),
    .bu_data_o       (bu_data_o),
    .bu_en_o         (bu_en_o),
    .bu_num_elem_o   (bu_num_elem_o),
    .out_ready_i     (out_ready_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
`ifdef BROADCAST_CTRL_PERF_EN
    .perf_stall_cnt_o(perf_stall_cnt_o),
    .perf_load_cnt_o (perf_load_cnt_o),
`endif
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // SRAM model: fixed latency, returns in issue order
  typedef struct { int due; logic [AW-1:0] addr; } rd_t;
  rd_t pend[$];
  int  lat = 1;
  int  cyc = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {8{a[7:0]}} ^ 64'h0123_4567_89ab_cdef;
  endfunction

  initial begin : sram_model
    rd_t r;
    sram_rd_valid_i = 1'b0;
    sram_rd_data_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      sram_rd_valid_i = 1'b0;
      sram_rd_data_i  = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        sram_rd_valid_i = 1'b1;
        sram_rd_data_i  = mem_word(r.addr);
      end
      @(negedge clk);
      if (sram_rd_en_o === 1'b1) pend.push_back('{cyc + lat, sram_rd_addr_o});
    end
  end

  // observation of DUT outputs, sampled on the falling edge
  int            m_rd_cnt, m_val_cnt, m_en_cnt, m_done_cnt, m_init_cnt, outs, m_max_out;
  logic [AW-1:0] m_rd_addr[$];
  logic [AW-1:0] m_val_addr[$];
  logic [DW-1:0] m_val_data[$];

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sram_rd_en_o === 1'b1) begin m_rd_cnt++; m_rd_addr.push_back(sram_rd_addr_o); end
      if (bu_valid_o === 1'b1) begin
        m_val_cnt++;
        m_val_addr.push_back(bu_addr_o);
        m_val_data.push_back(bu_data_o);
      end
      if (sram_rd_valid_i === 1'b1) outs--;
      if (sram_rd_en_o === 1'b1) outs++;
      if (outs > m_max_out) m_max_out = outs;
      if (bu_en_o === 1'b1)   m_en_cnt++;
      if (done_o === 1'b1)    m_done_cnt++;
      if (bu_init_o === 1'b1) m_init_cnt++;
    end
  end

  task automatic clr_mon();
    m_rd_cnt = 0; m_val_cnt = 0; m_en_cnt = 0; m_done_cnt = 0; m_init_cnt = 0;
    outs = 0; m_max_out = 0;
    m_rd_addr.delete(); m_val_addr.delete(); m_val_data.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] src, input int ne, input int nv);
    tick();
    start_i = 1'b1; src_addr_i = src; num_elem_i = ne; num_vec_i = nv;
    tick();
    start_i = 1'b0; src_addr_i = '0; num_elem_i = '0; num_vec_i = '0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (m_done_cnt > 0 && busy_o === 1'b0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL wait_idle: got busy=%b done_seen=%0d want idle after done", busy_o, m_done_cnt); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 0; src_addr_i = '0; num_elem_i = '0; num_vec_i = '0; out_ready_i = 1'b1;
    clr_mon();
    repeat (3) tick();
    total++;
    if ({busy_o, done_o, err_o, bu_init_o, bu_valid_o, bu_en_o, sram_rd_en_o} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0000000",
                      {busy_o, done_o, err_o, bu_init_o, bu_valid_o, bu_en_o, sram_rd_en_o});
    end
    total++;
    if (bu_num_elem_o !== '0) begin bad++; $display("FAIL reset_num_elem: got %0d want 0", bu_num_elem_o); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    lat = 1; out_ready_i = 1'b1;
    clr_mon();
    start_job(16'h0040, 20, 3);
    total++;
    if (bu_num_elem_o !== 32'd20) begin bad++; $display("FAIL basic_num_elem: got %0d want 20", bu_num_elem_o); end
    wait_idle(60);
    total++;
    if (m_rd_cnt !== 3) begin bad++; $display("FAIL basic_rd_cnt: got %0d want 3", m_rd_cnt); end
    for (int i = 0; i < 3; i++) begin
      ga = (i < m_rd_addr.size()) ? m_rd_addr[i] : 'x;
      total++;
      if (ga !== AW'(16'h40 + i)) begin bad++; $display("FAIL basic_rd_addr[%0d]: got %h want %h", i, ga, 16'h40 + i); end
      ga = (i < m_val_addr.size()) ? m_val_addr[i] : 'x;
      total++;
      if (ga !== AW'(i * 8)) begin bad++; $display("FAIL basic_bu_addr[%0d]: got %0d want %0d", i, ga, i * 8); end
      gd = (i < m_val_data.size()) ? m_val_data[i] : 'x;
      total++;
      if (gd !== mem_word(AW'(16'h40 + i))) begin bad++; $display("FAIL basic_bu_data[%0d]: got %h want %h", i, gd, mem_word(AW'(16'h40 + i))); end
    end
    total++;
    if (m_en_cnt !== 3) begin bad++; $display("FAIL basic_en_cnt: got %0d want 3", m_en_cnt); end
    total++;
    if (m_done_cnt !== 1) begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", m_done_cnt); end
    total++;
    if (m_init_cnt !== 1) begin bad++; $display("FAIL basic_init_cnt: got %0d want 1", m_init_cnt); end
    total++;
    if (err_o !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err_o); end
  endtask

  task automatic test_latency();
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    lat = 6; out_ready_i = 1'b1;
    clr_mon();
    start_job(16'h0100, 64, 2);
    wait_idle(150);
    total++;
    if (m_max_out !== 4) begin bad++; $display("FAIL lat_max_outstanding: got %0d want 4", m_max_out); end
    total++;
    if (m_rd_cnt !== 8) begin bad++; $display("FAIL lat_rd_cnt: got %0d want 8", m_rd_cnt); end
    total++;
    if (m_val_cnt !== 8) begin bad++; $display("FAIL lat_val_cnt: got %0d want 8", m_val_cnt); end
    for (int i = 0; i < 8; i++) begin
      ga = (i < m_rd_addr.size()) ? m_rd_addr[i] : 'x;
      total++;
      if (ga !== AW'(16'h100 + i)) begin bad++; $display("FAIL lat_rd_addr[%0d]: got %h want %h", i, ga, 16'h100 + i); end
      ga = (i < m_val_addr.size()) ? m_val_addr[i] : 'x;
      total++;
      if (ga !== AW'(i * 8)) begin bad++; $display("FAIL lat_bu_addr[%0d]: got %0d want %0d", i, ga, i * 8); end
      gd = (i < m_val_data.size()) ? m_val_data[i] : 'x;
      total++;
      if (gd !== mem_word(AW'(16'h100 + i))) begin bad++; $display("FAIL lat_bu_data[%0d]: got %h want %h", i, gd, mem_word(AW'(16'h100 + i))); end
    end
    total++;
    if (m_en_cnt !== 2) begin bad++; $display("FAIL lat_en_cnt: got %0d want 2", m_en_cnt); end
  endtask

  task automatic test_stall();
    logic [7:0] pat;
    bit seen;
    pat = 8'b1101_1001;  // bit i = ready in STREAM cycle i: 1,0,0,1,1,0,1,1
    lat = 1; out_ready_i = 1'b0;
    clr_mon();
    start_job(16'h0020, 8, 5);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_val_cnt >= 1) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL stall_load: got %0d returns want 1", m_val_cnt); end
    out_ready_i = pat[0];
    for (int i = 1; i < 8; i++) begin
      tick();
      out_ready_i = pat[i];
      if (i == 3) begin
        total++;
        if (m_en_cnt !== 1) begin bad++; $display("FAIL stall_held_cnt: got %0d want 1", m_en_cnt); end
        total++;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL stall_held_busy: got %b want 1", busy_o); end
      end
    end
    tick();
    out_ready_i = 1'b1;
    wait_idle(20);
    total++;
    if (m_en_cnt !== 5) begin bad++; $display("FAIL stall_en_cnt: got %0d want 5", m_en_cnt); end
    total++;
    if (m_done_cnt !== 1) begin bad++; $display("FAIL stall_done_cnt: got %0d want 1", m_done_cnt); end
`ifdef BROADCAST_CTRL_PERF_EN
    total++;
    if (perf_stall_cnt_o !== 32'd3) begin bad++; $display("FAIL perf_stall: got %0d want 3", perf_stall_cnt_o); end
    total++;
    if (perf_load_cnt_o !== 32'd2) begin bad++; $display("FAIL perf_load: got %0d want 2", perf_load_cnt_o); end
`endif
  endtask

  task automatic test_errors();
    lat = 1; out_ready_i = 1'b1;
    clr_mon();
    start_job(16'h0010, 0, 4);
    wait_idle(10);
    total++;
    if ({err_o, m_rd_cnt == 0, m_en_cnt == 0, m_init_cnt == 0, m_done_cnt == 1} !== 5'b11111) begin
      bad++; $display("FAIL err_zero_elem: got err=%b rd=%0d en=%0d init=%0d done=%0d want 1/0/0/0/1",
                      err_o, m_rd_cnt, m_en_cnt, m_init_cnt, m_done_cnt);
    end
    repeat (3) tick();
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err_o); end
    clr_mon();
    start_job(16'h0010, 600, 4);
    wait_idle(10);
    total++;
    if ({err_o, m_rd_cnt == 0, m_en_cnt == 0, m_init_cnt == 0, m_done_cnt == 1} !== 5'b11111) begin
      bad++; $display("FAIL err_big_elem: got err=%b rd=%0d en=%0d init=%0d done=%0d want 1/0/0/0/1",
                      err_o, m_rd_cnt, m_en_cnt, m_init_cnt, m_done_cnt);
    end
    clr_mon();
    start_job(16'h0400, 512, 1);
    total++;
    if (err_o !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b want 0", err_o); end
    wait_idle(200);
    total++;
    if (m_rd_cnt !== 64) begin bad++; $display("FAIL depth_rd_cnt: got %0d want 64", m_rd_cnt); end
    total++;
    if (m_en_cnt !== 1) begin bad++; $display("FAIL depth_en_cnt: got %0d want 1", m_en_cnt); end
    clr_mon();
    start_job(16'h0010, 8, 0);
    wait_idle(10);
    total++;
    if ({err_o, m_rd_cnt == 0, m_en_cnt == 0} !== 3'b111) begin
      bad++; $display("FAIL err_zero_vec: got err=%b rd=%0d en=%0d want 1/0/0", err_o, m_rd_cnt, m_en_cnt);
    end
  endtask

  task automatic test_reset_midload();
    bit seen;
    lat = 6; out_ready_i = 1'b1;
    clr_mon();
    start_job(16'h0200, 64, 2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_rd_cnt >= 2) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || m_rd_cnt !== 2) begin bad++; $display("FAIL rst_mid_issue: got %0d reads want 2", m_rd_cnt); end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({busy_o, done_o, err_o, bu_init_o, bu_valid_o, bu_en_o, sram_rd_en_o} !== 7'b0) begin
      bad++; $display("FAIL rst_mid_outputs: got %b want 0000000",
                      {busy_o, done_o, err_o, bu_init_o, bu_valid_o, bu_en_o, sram_rd_en_o});
    end
    tick();
    rst = 1'b0;
    clr_mon();
    repeat (12) tick();
    total++;
    if (m_val_cnt !== 0) begin bad++; $display("FAIL rst_late_returns: got %0d bu_valid want 0", m_val_cnt); end
    total++;
    if (m_rd_cnt !== 0 || busy_o !== 1'b0) begin bad++; $display("FAIL rst_idle: got rd=%0d busy=%b want 0/0", m_rd_cnt, busy_o); end
    lat = 1;
    clr_mon();
    start_job(16'h0040, 20, 3);
    wait_idle(60);
    total++;
    if ({m_rd_cnt == 3, m_val_cnt == 3, m_en_cnt == 3, m_done_cnt == 1} !== 4'b1111) begin
      bad++; $display("FAIL rst_rerun: got rd=%0d val=%0d en=%0d done=%0d want 3/3/3/1",
                      m_rd_cnt, m_val_cnt, m_en_cnt, m_done_cnt);
    end
    total++;
    if (m_val_addr.size() != 3 || m_val_addr[2] !== AW'(16)) begin
      bad++; $display("FAIL rst_rerun_addr: got %0d entries want last addr 16", m_val_addr.size());
    end
  endtask

  task automatic test_restart_ignored();
    bit seen;
    lat = 1; out_ready_i = 1'b1;
    clr_mon();
    start_job(16'h0040, 20, 3);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (m_en_cnt >= 1) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL restart_reach_stream: got %0d en want >=1", m_en_cnt); end
    start_i = 1'b1; src_addr_i = 16'h0300; num_elem_i = 100; num_vec_i = 7;
    tick();
    start_i = 1'b0; src_addr_i = '0; num_elem_i = '0; num_vec_i = '0;
    wait_idle(20);
    total++;
    if (m_en_cnt !== 3) begin bad++; $display("FAIL restart_en_cnt: got %0d want 3", m_en_cnt); end
    total++;
    if (bu_num_elem_o !== 32'd20) begin bad++; $display("FAIL restart_num_elem: got %0d want 20", bu_num_elem_o); end
    repeat (10) tick();
    total++;
    if (m_rd_cnt !== 3 || m_done_cnt !== 1 || busy_o !== 1'b0) begin
      bad++; $display("FAIL restart_no_new_job: got rd=%0d done=%0d busy=%b want 3/1/0", m_rd_cnt, m_done_cnt, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_stall();
    test_errors();
    test_reset_midload();
    test_restart_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
